flt2fix_seq_param: RTL and testbench
====================================

// Module: flt2fix_seq_param
// PURPOSE
//  Sequential IEEE-style float -> fixed-point converter; parametrised successor of the half -> 8.8 converter.
//  Adds selectable rounding (truncate / round-nearest-even), sign-magnitude or two's-complement output,
//  and overflow / inexact flags. Uses a start/done handshake and sits beside the core as a conversion accelerator.
// PARAMETERS
//  EXP_W   5   exponent field width
//  MAN_W   10  stored mantissa (fraction) width
//  BIAS    15  exponent bias
//  INT_W   8   fixed integer bits, including the sign bit
//  FRAC_W  8   fixed fraction bits
//  Derived: FIX_W = INT_W+FRAC_W; MAG_W = FIX_W-1; EMAX = INT_W-1; NCAP = MAN_W+2
// PORTS
//  clk       in   1               rising-edge clock
//  reset     in   1               synchronous, active-high
//  start     in   1               request pulse; sampled only in IDLE or DONE
//  flt_in    in   1+EXP_W+MAN_W   {sign, exp, man}; captured when start is accepted
//  rnd_mode  in   1               0 = truncate magnitude toward zero, 1 = round-nearest-even; captured with flt_in
//  twos_c    in   1               0 = sign-magnitude output, 1 = two's complement; captured with flt_in
//  busy      out  1               high in UNPACK, SHIFT and ROUND
//  done      out  1               one-cycle pulse; results valid
//  fix_out   out  FIX_W           result; held from DONE until the next accepted start
//  ovf       out  1               saturated (range overflow, Inf/NaN, or rounding carry-out)
//  inexact   out  1               nonzero bits discarded (guard|sticky), and not ovf
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, fix_out=0, ovf=0, inexact=0.
//   Reset mid-operation aborts; the state is IDLE at the next edge and no done is produced.
//  FSM: IDLE -start-> UNPACK -> SHIFT (N cycles, skipped if N=0) -> ROUND -> DONE -> IDLE.
//   start in DONE is accepted; next state is UNPACK, so back-to-back conversions are allowed.
//   start in UNPACK, SHIFT or ROUND is ignored, with no effect on the conversion in progress.
//  UNPACK:
//   - hidden bit = |exp; sig = {hidden, man} (MAN_W+1 bits).
//   - e = exp-BIAS if exp != 0; e = 1-BIAS for a subnormal.
//   - sh = e-MAN_W+FRAC_W.
//   - Special cases (N=0, SHIFT skipped):
//     - exp all ones (Inf/NaN), or e >= EMAX: saturate, mag = all ones (MAG_W bits), ovf = 1.
//     - exp=0 and man=0: mag = 0, exact.
//   - Otherwise N = |sh| if sh >= 0, else min(-sh, NCAP).
//  SHIFT: one bit position per cycle.
//   - sh >= 0: left shift. This is lossless because e < EMAX guarantees a fit in MAG_W.
//   - sh < 0: right shift, keeping guard = last bit shifted out, and sticky |= previous guard.
//  ROUND:
//   - rnd_mode=1: increment if guard & (sticky | lsb).
//   - A carry out of MAG_W saturates and sets ovf.
//   - inexact = (guard|sticky) & !ovf.
//  DONE: done=1 for exactly one cycle.
//   - twos_c=0: fix_out = {sign, mag}. Negative zero gives 1 followed by zeros.
//   - twos_c=1: fix_out = sign ? -{0,mag} : {0,mag}.
//     - -0 gives 0.
//     - Negative saturation gives -(2^MAG_W - 1), i.e. 0x8001 at the defaults; the range is symmetric.
//  Latency: start accepted at edge 0 -> done high in cycle 3+N. Worst case 3+max(NCAP, FRAC_W-MAN_W+EMAX-1).
// TESTING (defaults)
//  1. 0x3C00 (1.0), trunc, SM -> fix_out=0x0100, ovf=0, inexact=0; N=2, done in cycle 5.
//  2. 0xC500 (-5.0): SM -> 0x8500; twos_c=1 -> 0xFB00. 0x57FF -> 0x7FF0 (left shift N=4, done cycle 7).
//  3. 0x3C03 (256.75/256): trunc -> 0x0100, inexact=1; RNE -> 0x0101.
//     0x3C02 (tie): RNE -> 0x0100, inexact=1.
//  4. 0x7780 (e=14) -> 0x7FFF, ovf=1.
//     0xFB80 with twos_c=1 -> 0x8001, ovf=1.
//     0x7C00 (Inf) -> 0x7FFF, ovf=1, done in cycle 3.
//  5. 0x8000: SM -> 0x8000, twos -> 0x0000, done in cycle 3.
//     0x0001 (subnormal) -> 0x0000, inexact=1, N=12.
//  6. start pulses during SHIFT are ignored. Reset asserted in SHIFT -> IDLE, outputs 0, no done.
//     Then start pulsed in the DONE cycle -> second result correct.

Source files
------------

// File: rtl/flt2fix_seq_param.sv
// Sequential float -> fixed-point converter with selectable rounding,
// sign-magnitude / two's-complement output and overflow / inexact flags.
module flt2fix_seq_param #(
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int BIAS   = 15,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [EXP_W+MAN_W:0]     flt_in,
    input  logic                     rnd_mode,
    input  logic                     twos_c,
    output logic                     busy,
    output logic                     done,
    output logic [INT_W+FRAC_W-1:0]  fix_out,
    output logic                     ovf,
    output logic                     inexact
);

    localparam int FIX_W = INT_W + FRAC_W;
    localparam int MAG_W = FIX_W - 1;
    localparam int EMAX  = INT_W - 1;
    localparam int NCAP  = MAN_W + 2;
    localparam int LMAX  = FRAC_W - MAN_W + EMAX - 1;
    localparam int NMAX  = (NCAP > LMAX) ? NCAP : LMAX;
    localparam int CNT_W = $clog2(NMAX + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [EXP_W+MAN_W:0]   flt_q, flt_d;
    logic                   rnd_q, rnd_d;
    logic                   tc_q, tc_d;
    logic                   left_q, left_d;
    logic                   sat_q, sat_d;
    logic [MAG_W-1:0]       mag_q, mag_d;
    logic                   guard_q, guard_d;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [FIX_W-1:0]       fix_q, fix_d;
    logic                   ovf_q, ovf_d;
    logic                   inexact_q, inexact_d;

    logic [EXP_W-1:0]       exp_f;
    logic [MAN_W-1:0]       man_f;
    logic                   sign_f;
    int                     e_v;
    int                     sh_v;
    int                     n_v;
    logic                   inc;
    logic [MAG_W:0]         sum;
    logic [MAG_W-1:0]       mag_fin;
    logic                   ovf_fin;

    assign exp_f  = flt_q[MAN_W +: EXP_W];
    assign man_f  = flt_q[MAN_W-1:0];
    assign sign_f = flt_q[EXP_W+MAN_W];
    assign e_v    = (exp_f != '0) ? int'(exp_f) - BIAS : 1 - BIAS;
    assign sh_v   = e_v - MAN_W + FRAC_W;
    // Right shifts past NCAP only feed sticky, so the count is capped there.
    assign n_v    = (sh_v >= 0) ? sh_v : ((-sh_v > NCAP) ? NCAP : -sh_v);

    assign inc     = rnd_q & guard_q & (sticky_q | mag_q[0]);
    assign sum     = {1'b0, mag_q} + {{MAG_W{1'b0}}, inc};
    assign mag_fin = sum[MAG_W] ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
    assign ovf_fin = sat_q | sum[MAG_W];

    always_comb begin
        state_d   = state_q;
        flt_d     = flt_q;
        rnd_d     = rnd_q;
        tc_d      = tc_q;
        left_d    = left_q;
        sat_d     = sat_q;
        mag_d     = mag_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fix_d     = fix_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    flt_d   = flt_in;
                    rnd_d   = rnd_mode;
                    tc_d    = twos_c;
                    busy_d  = 1'b1;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                sat_d    = 1'b0;
                left_d   = 1'b0;
                cnt_d    = '0;
                mag_d    = MAG_W'({|exp_f, man_f});
                if ((&exp_f) || e_v >= EMAX) begin
                    mag_d = {MAG_W{1'b1}};
                    sat_d = 1'b1;
                end else if (exp_f == '0 && man_f == '0) begin
                    mag_d = '0;
                end else begin
                    left_d = (sh_v >= 0);
                    cnt_d  = CNT_W'(n_v);
                end
                state_d = (cnt_d == '0) ? S_ROUND : S_SHIFT;
            end
            S_SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d    = mag_q >> 1;
                    guard_d  = mag_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                ovf_d     = ovf_fin;
                inexact_d = (guard_q | sticky_q) & ~ovf_fin;
                if (tc_q)
                    fix_d = sign_f ? -{1'b0, mag_fin} : {1'b0, mag_fin};
                else
                    fix_d = {sign_f, mag_fin};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            flt_q     <= '0;
            rnd_q     <= 1'b0;
            tc_q      <= 1'b0;
            left_q    <= 1'b0;
            sat_q     <= 1'b0;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fix_q     <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flt_q     <= flt_d;
            rnd_q     <= rnd_d;
            tc_q      <= tc_d;
            left_q    <= left_d;
            sat_q     <= sat_d;
            mag_q     <= mag_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fix_q     <= fix_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign fix_out = fix_q;
    assign ovf     = ovf_q;
    assign inexact = inexact_q;

endmodule

// File: tb/tb_flt2fix_seq_param.sv
// Scoreboard bench for flt2fix_seq_param at default parameters:
// directed vectors plus randomized conversions against an arithmetic model.
module tb_flt2fix_seq_param;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] flt_in = '0;
    logic        rnd_mode = 1'b0;
    logic        twos_c = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] fix_out;
    logic        ovf;
    logic        inexact;

    flt2fix_seq_param dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flt_in   (flt_in),
        .rnd_mode (rnd_mode),
        .twos_c   (twos_c),
        .busy     (busy),
        .done     (done),
        .fix_out  (fix_out),
        .ovf      (ovf),
        .inexact  (inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fix;
        int ovf;
        int inx;
        int cyc;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Value = sig * 2^(e-10); scaled by 2^8 this is sig * 2^(e-2).
    function automatic exp_t model(int f, int rnd, int tc);
        exp_t   x;
        int     sgn, ex, man, e, sh, k, n;
        longint sig, mag, rem, half;
        int     ov, inx;
        sgn = (f >> 15) & 1;
        ex  = (f >> 10) & 31;
        man = f & 1023;
        sig = (ex != 0) ? 1024 + man : man;
        e   = (ex != 0) ? ex - 15 : -14;
        sh  = e - 2;
        ov  = 0;
        inx = 0;
        n   = 0;
        if (ex == 31 || e >= 7) begin
            mag = 32767;
            ov  = 1;
        end else if (sig == 0) begin
            mag = 0;
        end else if (sh >= 0) begin
            mag = sig << sh;
            n   = sh;
        end else begin
            k    = -sh;
            mag  = sig >> k;
            rem  = sig - (mag << k);
            half = longint'(1) << (k - 1);
            inx  = (rem != 0) ? 1 : 0;
            if (rnd != 0 && (rem > half || (rem == half && mag[0])))
                mag = mag + 1;
            if (mag > 32767) begin
                mag = 32767;
                ov  = 1;
                inx = 0;
            end
            n = (k > 12) ? 12 : k;
        end
        if (tc != 0)
            x.fix = (sgn != 0) ? int'((65536 - mag) & 65535) : int'(mag);
        else
            x.fix = sgn * 32768 + int'(mag);
        x.ovf = ov;
        x.inx = inx;
        x.cyc = 3 + n;
        x.acc = 0;
        return x;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got fix 0x%0h expected none", fix_out);
            end else begin
                x = sb.pop_front();
                chk("fix_out", int'(fix_out), x.fix);
                chk("ovf", int'(ovf), x.ovf);
                chk("inexact", int'(inexact), x.inx);
                chk("done_cycle", cyc - x.acc + 1, x.cyc);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic wait_done();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected done within 60 cycles");
    endtask

    task automatic issue(logic [15:0] f, bit r, bit t, exp_t x, bit noisy);
        start    = 1'b1;
        flt_in   = f;
        rnd_mode = r;
        twos_c   = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        x.acc = cyc;
        sb.push_back(x);
        chk("busy_after_start", int'(busy), 1);
        if (noisy) begin
            repeat (3) @(negedge clk);
            start    = 1'b1;
            flt_in   = 16'h3C00;
            rnd_mode = ~r;
            twos_c   = ~t;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    task automatic run_exp(logic [15:0] f, bit r, bit t,
                           int fx, int ov, int ix, int cy);
        exp_t x;
        x.fix = fx;
        x.ovf = ov;
        x.inx = ix;
        x.cyc = cy;
        x.acc = 0;
        issue(f, r, t, x, 1'b0);
    endtask

    task automatic run(logic [15:0] f, bit r, bit t);
        issue(f, r, t, model(int'(f), int'(r), int'(t)), 1'b0);
    endtask

    initial begin
        int          ndone;
        logic [15:0] f;
        int          rv;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fix", int'(fix_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_inexact", int'(inexact), 0);
        @(negedge clk);

        run_exp(16'h3C00, 0, 0, 16'h0100, 0, 0, 5);
        run_exp(16'hC500, 0, 0, 16'h8500, 0, 0, 3);
        run_exp(16'hC500, 0, 1, 16'hFB00, 0, 0, 3);
        run_exp(16'h57FF, 0, 0, 16'h7FF0, 0, 0, 7);
        run_exp(16'h3C03, 0, 0, 16'h0100, 0, 1, 5);
        run_exp(16'h3C03, 1, 0, 16'h0101, 0, 1, 5);
        run_exp(16'h3C02, 1, 0, 16'h0100, 0, 1, 5);
        run_exp(16'h7780, 0, 0, 16'h7FFF, 1, 0, 3);
        run_exp(16'hFB80, 0, 1, 16'h8001, 1, 0, 3);
        run_exp(16'h7C00, 0, 0, 16'h7FFF, 1, 0, 3);
        run_exp(16'h8000, 0, 0, 16'h8000, 0, 0, 3);
        run_exp(16'h8000, 0, 1, 16'h0000, 0, 0, 3);
        run_exp(16'h0001, 0, 0, 16'h0000, 0, 1, 15);

        // start pulses while shifting must not disturb the conversion
        issue(16'h0001, 1'b1, 1'b0, model(16'h0001, 1, 0), 1'b1);
        issue(16'hBC07, 1'b1, 1'b1, model(16'hBC07, 1, 1), 1'b1);

        // reset in the middle of a conversion aborts without done
        repeat (2) @(negedge clk);
        start  = 1'b1;
        flt_in = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_fix", int'(fix_out), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_inexact", int'(inexact), 0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // second start lands in the DONE cycle of the first
        run(16'h4248, 1'b1, 1'b0);
        run(16'hC248, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            rv = int'($urandom_range(0, 3));
            repeat (rv == 0 ? int'($urandom_range(1, 3)) : 0) @(negedge clk);
            f = 16'($urandom());
            if ($urandom_range(0, 1) == 1)
                f[14:10] = 5'($urandom_range(0, 22));
            run(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
